// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture engine: state width and state encoding.
package la_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } la_state_e;

endpackage

// File: rtl/la_rd_if.sv
// Readout bus of the capture buffer. Optional timestamp lane present when LA_TIMESTAMP_EN is defined.
interface la_rd_if #(
  parameter int PROBE_W = 8,
  parameter int AW      = 10
`ifdef LA_TIMESTAMP_EN
  , parameter int TS_W  = 16
`endif
);

  // Handshake: rd_en is a request with no backpressure; rd_valid rises exactly one cycle
  // after an accepted rd_en (only while the capture is DONE), carrying rd_data for rd_addr.
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic [PROBE_W-1:0] rd_data;
  logic               rd_valid;
`ifdef LA_TIMESTAMP_EN
  logic [TS_W-1:0]    rd_ts;

  modport master (output rd_en, rd_addr, input rd_data, rd_valid, rd_ts);
  modport slave  (input rd_en, rd_addr, output rd_data, rd_valid, rd_ts);
`else
  modport master (output rd_en, rd_addr, input rd_data, rd_valid);
  modport slave  (input rd_en, rd_addr, output rd_data, rd_valid);
`endif

endinterface

// File: rtl/la_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port (block-RAM style).
module la_sample_ram #(
  parameter  int W     = 8,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: decimated sampling, masked level/edge trigger, pre-trigger window.
// Define LA_TIMESTAMP_EN to store a free-running timestamp with every sample (rd.rd_ts).
module la_capture_core
  import la_pkg::*;
#(
  parameter  int PROBE_W = 8,
  parameter  int DEPTH   = 1024,
  parameter  int DEC_W   = 8,
  parameter  int TS_W    = 16,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [PROBE_W-1:0] data_i,
  input  logic               arm_i,
  input  logic               abort_i,
  input  logic [PROBE_W-1:0] trig_val_i,
  input  logic [PROBE_W-1:0] trig_mask_i,
  input  logic [PROBE_W-1:0] trig_edge_i,
  input  logic [AW-1:0]      pretrig_i,
  input  logic [DEC_W-1:0]   decim_i,
  la_rd_if.slave             rd,
  output logic [STATE_W-1:0] state_o,
  output logic               done_o,
  output logic [AW-1:0]      trig_addr_o
);

  localparam logic [STATE_W-1:0] S_IDLE = ST_IDLE;
  localparam logic [STATE_W-1:0] S_PRE  = ST_PRE;
  localparam logic [STATE_W-1:0] S_WAIT = ST_WAIT;
  localparam logic [STATE_W-1:0] S_POST = ST_POST;
  localparam logic [STATE_W-1:0] S_DONE = ST_DONE;

`ifdef LA_TIMESTAMP_EN
  localparam int TS_USED = 1;
`else
  localparam int TS_USED = 0;
`endif
  localparam int RAM_W = PROBE_W + TS_USED * TS_W;

  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [DEC_W-1:0]   dec_q, dec_d;
  logic [DEC_W-1:0]   decim_q, decim_d;
  logic [PROBE_W-1:0] prev_q, prev_d;
  logic               prev_vld_q, prev_vld_d;
  logic [PROBE_W-1:0] val_q, val_d, mask_q, mask_d, edge_q, edge_d;
  logic [AW-1:0]      pre_q, pre_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [AW-1:0]      trig_addr_q, trig_addr_d;
  logic               done_q, done_d;
  logic               rd_valid_q;

  logic               active, strobe, hit, we, re;
  logic [AW:0]        post_need;
  logic [AW-1:0]      raddr;
  logic [RAM_W-1:0]   wdata, rdata;

  assign active = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign strobe = active && (dec_q == '0);

  // Per bit: ignored, or equal to val and (level bit, or edge bit whose previous sample differed).
  assign hit = &(~mask_q | (~(data_i ^ val_q) & (~edge_q | ({PROBE_W{prev_vld_q}} & (prev_q ^ val_q)))));

  // The trigger sample itself counts as the first post sample.
  assign post_need = (AW+1)'(DEPTH) - {1'b0, pre_q};

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    dec_d       = dec_q;
    decim_d     = decim_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    val_d       = val_q;
    mask_d      = mask_q;
    edge_d      = edge_q;
    pre_d       = pre_q;
    cnt_d       = cnt_q;
    trig_addr_d = trig_addr_q;
    done_d      = done_q;
    we          = 1'b0;

    if (active) dec_d = (dec_q == '0) ? decim_q : dec_q - DEC_W'(1);
    if (strobe) begin
      prev_d     = data_i;
      prev_vld_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm_i) begin
          // pretrig_i is AW bits wide, so its largest value is already DEPTH-1.
          val_d      = trig_val_i;
          mask_d     = trig_mask_i;
          edge_d     = trig_edge_i;
          pre_d      = pretrig_i;
          decim_d    = decim_i;
          dec_d      = decim_i;
          wptr_d     = '0;
          cnt_d      = '0;
          prev_vld_d = 1'b0;
          done_d     = 1'b0;
          state_d    = (pretrig_i == '0) ? S_WAIT : S_PRE;
        end
      end
      S_PRE: begin
        if (strobe) begin
          we     = 1'b1;
          wptr_d = wptr_q + AW'(1);
          if (cnt_q == {1'b0, pre_q} - CNT_ONE) begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_WAIT: begin
        if (strobe) begin
          we     = 1'b1;
          wptr_d = wptr_q + AW'(1);
          if (hit) begin
            trig_addr_d = wptr_q;
            cnt_d       = CNT_ONE;
            if (post_need == CNT_ONE) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_POST;
            end
          end
        end
      end
      S_POST: begin
        if (strobe) begin
          we     = 1'b1;
          wptr_d = wptr_q + AW'(1);
          cnt_d  = cnt_q + CNT_ONE;
          if (cnt_q + CNT_ONE == post_need) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      we      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      dec_q       <= '0;
      decim_q     <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      val_q       <= '0;
      mask_q      <= '0;
      edge_q      <= '0;
      pre_q       <= '0;
      cnt_q       <= '0;
      trig_addr_q <= '0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      dec_q       <= dec_d;
      decim_q     <= decim_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      val_q       <= val_d;
      mask_q      <= mask_d;
      edge_q      <= edge_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      trig_addr_q <= trig_addr_d;
      done_q      <= done_d;
      rd_valid_q  <= re;
    end
  end

  // Reads only happen in DONE, when no writes occur, so the ports never collide.
  assign re    = rd.rd_en && (state_q == S_DONE);
  assign raddr = trig_addr_q - pre_q + rd.rd_addr;

`ifdef LA_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ts_q <= '0;
    else       ts_q <= ts_q + TS_W'(1);
  end

  assign wdata    = {ts_q, data_i};
  assign rd.rd_ts = rdata[PROBE_W +: TS_W];
`else
  assign wdata = data_i;
`endif

  la_sample_ram #(
    .W     (RAM_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (we),
    .waddr_i (wptr_q),
    .wdata_i (wdata),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign rd.rd_data  = rdata[PROBE_W-1:0];
  assign rd.rd_valid = rd_valid_q;
  assign state_o     = state_q;
  assign done_o      = done_q;
  assign trig_addr_o = trig_addr_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Self-checking bench for la_capture_core (PROBE_W=8, DEPTH=16): expected captures are queued at arm time.
module tb_la_capture_core;

  localparam int PW = 8;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] data_i = '0;
  logic          arm_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [PW-1:0] trig_val_i = '0, trig_mask_i = '0, trig_edge_i = '0;
  logic [AW-1:0] pretrig_i = '0;
  logic [7:0]    decim_i = '0;
  logic [2:0]    state_o;
  logic          done_o;
  logic [AW-1:0] trig_addr_o;

  logic          ramp_on = 1'b0;
  int            errors = 0;
  int            checks = 0;
  logic [PW-1:0] exp_q[$];

  la_rd_if #(.PROBE_W(PW), .AW(AW)) rd_if ();

  la_capture_core #(.PROBE_W(PW), .DEPTH(DP), .DEC_W(8), .TS_W(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .data_i      (data_i),
    .arm_i       (arm_i),
    .abort_i     (abort_i),
    .trig_val_i  (trig_val_i),
    .trig_mask_i (trig_mask_i),
    .trig_edge_i (trig_edge_i),
    .pretrig_i   (pretrig_i),
    .decim_i     (decim_i),
    .rd          (rd_if),
    .state_o     (state_o),
    .done_o      (done_o),
    .trig_addr_o (trig_addr_o)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; a running ramp advances once per cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ramp_on) data_i = data_i + 8'd1;
  endtask

  task automatic arm_cfg(input logic [7:0] val, input logic [7:0] mask, input logic [7:0] edg,
                         input logic [3:0] pre, input logic [7:0] dec);
    trig_val_i  = val;
    trig_mask_i = mask;
    trig_edge_i = edg;
    pretrig_i   = pre;
    decim_i     = dec;
    arm_i       = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  task automatic push_ramp(input logic [7:0] first, input logic [7:0] step);
    logic [7:0] v;
    v = first;
    for (int i = 0; i < DP; i++) begin
      exp_q.push_back(v);
      v = v + step;
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input string name);
    int n;
    n = 0;
    while (state_o !== st && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (state_o !== st) begin
      errors++;
      $display("FAIL %s: state=%0d required=%0d (timeout)", name, state_o, st);
    end
  endtask

  task automatic read_capture(input string name);
    logic [PW-1:0] e;
    for (int i = 0; i < DP; i++) begin
      rd_if.rd_en   = 1'b1;
      rd_if.rd_addr = AW'(i);
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== e) begin
        errors++;
        $display("FAIL %s idx%0d: data=%h valid=%b required=%h valid=1", name, i, rd_if.rd_data, rd_if.rd_valid, e);
      end
    end
    rd_if.rd_en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    checks++;
    if (state_o !== 3'd0 || done_o !== 1'b0 || trig_addr_o !== 4'd0 ||
        rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset: state=%0d done=%b taddr=%0d valid=%b data=%h required all 0",
               state_o, done_o, trig_addr_o, rd_if.rd_valid, rd_if.rd_data);
    end
  endtask

  task automatic test_level_trigger();
    data_i  = 8'h00;
    ramp_on = 1'b1;
    push_ramp(8'h3C, 8'd1);
    arm_cfg(8'h40, 8'hFF, 8'h00, 4'd4, 8'd0);
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL level_arm_state: state=%0d required=1", state_o);
    end
    wait_state(3'd4, "level_done");
    ramp_on = 1'b0;
    checks++;
    if (done_o !== 1'b1 || trig_addr_o !== 4'd15) begin
      errors++;
      $display("FAIL level_taddr: done=%b taddr=%0d required done=1 taddr=15", done_o, trig_addr_o);
    end
    read_capture("level_read");
  endtask

  task automatic test_edge_trigger();
    ramp_on = 1'b0;
    data_i  = 8'h01;
    push_ramp(8'h03, 8'd1);
    arm_cfg(8'h01, 8'h01, 8'h01, 4'd0, 8'd0);
    repeat (30) tick();
    checks++;
    if (state_o !== 3'd2 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL edge_hold: state=%0d done=%b required state=2 done=0", state_o, done_o);
    end
    data_i = 8'h00;
    tick();
    tick();
    data_i  = 8'h03;
    ramp_on = 1'b1;
    wait_state(3'd4, "edge_done");
    ramp_on = 1'b0;
    read_capture("edge_read");
  endtask

  task automatic test_decimation();
    data_i  = 8'h00;
    ramp_on = 1'b1;
    push_ramp(8'd3, 8'd3);
    arm_cfg(8'h00, 8'h00, 8'h00, 4'd0, 8'd2);
    wait_state(3'd4, "decim_done");
    ramp_on = 1'b0;
    read_capture("decim_read");
  endtask

  task automatic test_wrap();
    data_i  = 8'h00;
    ramp_on = 1'b1;
    push_ramp(8'h24, 8'd1);
    arm_cfg(8'h28, 8'hFF, 8'h00, 4'd4, 8'd0);
    wait_state(3'd4, "wrap_done");
    ramp_on = 1'b0;
    checks++;
    if (trig_addr_o !== 4'd7) begin
      errors++;
      $display("FAIL wrap_taddr: taddr=%0d required=7", trig_addr_o);
    end
    read_capture("wrap_read");
  endtask

  task automatic test_abort();
    data_i  = 8'h00;
    ramp_on = 1'b1;
    arm_cfg(8'h10, 8'hFF, 8'h00, 4'd4, 8'd0);
    wait_state(3'd3, "abort_reach_post");
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    ramp_on = 1'b0;
    checks++;
    if (state_o !== 3'd0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_post: state=%0d done=%b required state=0 done=0", state_o, done_o);
    end
    arm_i   = 1'b1;
    abort_i = 1'b1;
    tick();
    arm_i   = 1'b0;
    abort_i = 1'b0;
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL arm_abort: state=%0d required=0", state_o);
    end
    rd_if.rd_en   = 1'b1;
    rd_if.rd_addr = AW'($urandom_range(0, DP-1));
    tick();
    rd_if.rd_en = 1'b0;
    checks++;
    if (rd_if.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_idle: valid=%b required=0", rd_if.rd_valid);
    end
  endtask

  task automatic test_pretrig_max();
    data_i  = 8'h00;
    ramp_on = 1'b1;
    push_ramp(8'h21, 8'd1);
    arm_cfg(8'h30, 8'hFF, 8'h00, 4'd15, 8'd0);
    wait_state(3'd2, "max_reach_wait");
    rd_if.rd_en   = 1'b1;
    rd_if.rd_addr = 4'd0;
    tick();
    rd_if.rd_en = 1'b0;
    checks++;
    if (rd_if.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_wait: valid=%b required=0", rd_if.rd_valid);
    end
    wait_state(3'd4, "max_done");
    ramp_on = 1'b0;
    checks++;
    if (trig_addr_o !== 4'd15) begin
      errors++;
      $display("FAIL max_taddr: taddr=%0d required=15", trig_addr_o);
    end
    read_capture("max_read");
  endtask

  initial begin
    rd_if.rd_en   = 1'b0;
    rd_if.rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    tick();
    test_reset();
    test_level_trigger();
    test_edge_trigger();
    test_decimation();
    test_wrap();
    test_abort();
    test_pretrig_max();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
